// File: rtl/vec_lane_sequencer.sv
// vec_lane_sequencer: multi-cycle vector execute controller.
// Streams one vector operation through a single external combinational
// Q7.8 lane ALU, one lane per cycle, and hands the assembled result vector,
// per-lane flags and aggregated {V,N,Z,C} flags to writeback.
// Optional feature macro: VEC_LANE_SEQ_MASK_EN adds a per-lane enable mask
// (masked lanes pass operand C through with zero flags and are left out of
// the flag aggregation).
module vec_lane_sequencer #(
    parameter int LANES = 4,
    parameter int IDX_W = $clog2(LANES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_opcode,
    input  logic                  in_scalar,
    input  logic [15:0]           in_scalar_val,
    input  logic [16*LANES-1:0]   in_vec_a,
    input  logic [16*LANES-1:0]   in_vec_b,
    input  logic [16*LANES-1:0]   in_vec_c,
`ifdef VEC_LANE_SEQ_MASK_EN
    input  logic [LANES-1:0]      in_mask,
`endif
    output logic [15:0]           alu_a,
    output logic [15:0]           alu_b,
    output logic [15:0]           alu_c,
    output logic [2:0]            alu_opcode,
    output logic                  alu_flag_scalar,
    output logic [31:0]           alu_instance,
    input  logic [15:0]           alu_result,
    input  logic [3:0]            alu_flags,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*LANES-1:0]   out_vec,
    output logic [4*LANES-1:0]    out_lane_flags,
    output logic [3:0]            out_flags,
    output logic                  out_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Opcodes the lane ALU understands: mul, sub, add, set.
    function automatic logic f_legal(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op == 3'b111);
    endfunction

    // Reduce per-lane {V,N,Z,C}: OR for V/N/C, AND for Z, inactive lanes
    // behave as the identity of each reduction (Z=1, others 0).
    function automatic logic [3:0] f_aggregate(input logic [4*LANES-1:0] lf,
                                               input logic [LANES-1:0]   act);
        logic v, n, z, c;
        v = 1'b0;
        n = 1'b0;
        z = 1'b1;
        c = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (act[i]) begin
                v = v | lf[4*i+3];
                n = n | lf[4*i+2];
                z = z & lf[4*i+1];
                c = c | lf[4*i+0];
            end
        end
        return {v, n, z, c};
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [2:0]            r_opcode;
    logic                  r_scalar;
    logic [15:0]           r_scalar_val;
    logic [16*LANES-1:0]   r_vec_a;
    logic [16*LANES-1:0]   r_vec_b;
    logic [16*LANES-1:0]   r_vec_c;
    logic [16*LANES-1:0]   r_res;
    logic [4*LANES-1:0]    r_lflags;
    logic [3:0]            r_flags;
    logic                  r_err;
`ifdef VEC_LANE_SEQ_MASK_EN
    logic [LANES-1:0]      r_mask;
`endif

    logic                  w_accept;
    logic                  w_last;
    logic [IDX_W-1:0]      w_lane;
    logic [15:0]           w_lane_res;
    logic [3:0]            w_lane_flg;
    logic [4*LANES-1:0]    w_lflags_upd;
    logic [LANES-1:0]      w_active;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_idx == IDX_W'(LANES - 1));
    // Outside RUN the ALU sees lane 0 so its inputs never dangle on a stale index.
    assign w_lane   = (r_state == S_RUN) ? r_idx : '0;

`ifdef VEC_LANE_SEQ_MASK_EN
    assign w_active = r_mask;
`else
    assign w_active = '1;
`endif

    // ALU operand drive: purely combinational from latched operands and lane index.
    assign alu_a           = r_vec_a[{w_lane, 4'b0000} +: 16];
    assign alu_b           = r_scalar ? r_scalar_val : r_vec_b[{w_lane, 4'b0000} +: 16];
    assign alu_c           = r_vec_c[{w_lane, 4'b0000} +: 16];
    assign alu_opcode      = r_opcode;
    assign alu_flag_scalar = r_scalar;
    assign alu_instance    = 32'(w_lane);

    assign out_vec        = r_res;
    assign out_lane_flags = r_lflags;
    assign out_flags      = r_flags;
    assign out_err        = r_err;

    // Per-lane writeback value; a masked lane forwards operand C with zero flags.
    always_comb begin
        w_lane_res = alu_result;
        w_lane_flg = alu_flags;
`ifdef VEC_LANE_SEQ_MASK_EN
        if (!r_mask[r_idx]) begin
            w_lane_res = alu_c;
            w_lane_flg = 4'b0000;
        end
`endif
    end

    // Lane flag vector including the lane being written this cycle, so the
    // aggregate taken on the last lane already sees that lane's flags.
    always_comb begin
        w_lflags_upd = r_lflags;
        w_lflags_upd[{r_idx, 2'b00} +: 4] = w_lane_flg;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = f_legal(in_opcode) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture at accept, per-lane result collection, flag aggregation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx        <= '0;
            r_opcode     <= '0;
            r_scalar     <= 1'b0;
            r_scalar_val <= '0;
            r_vec_a      <= '0;
            r_vec_b      <= '0;
            r_vec_c      <= '0;
            r_res        <= '0;
            r_lflags     <= '0;
            r_flags      <= '0;
            r_err        <= 1'b0;
`ifdef VEC_LANE_SEQ_MASK_EN
            r_mask       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx        <= '0;
                        r_opcode     <= in_opcode;
                        r_scalar     <= in_scalar;
                        r_scalar_val <= in_scalar_val;
                        r_vec_a      <= in_vec_a;
                        r_vec_b      <= in_vec_b;
                        r_vec_c      <= in_vec_c;
                        r_res        <= '0;
                        r_lflags     <= '0;
                        r_flags      <= '0;
                        r_err        <= !f_legal(in_opcode);
`ifdef VEC_LANE_SEQ_MASK_EN
                        r_mask       <= in_mask;
`endif
                    end
                end
                S_RUN: begin
                    r_res[{r_idx, 4'b0000} +: 16] <= w_lane_res;
                    r_lflags                      <= w_lflags_upd;
                    if (w_last) begin
                        r_flags <= f_aggregate(w_lflags_upd, w_active);
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_err <= 1'b0;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Self-checking bench for vec_lane_sequencer (LANES=4) with a behavioural
// Q7.8 lane ALU and a queue of expected result vectors.
module tb_vec_lane_sequencer;

    localparam int LANES = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_opcode;
    logic                in_scalar;
    logic [15:0]         in_scalar_val;
    logic [16*LANES-1:0] in_vec_a;
    logic [16*LANES-1:0] in_vec_b;
    logic [16*LANES-1:0] in_vec_c;
`ifdef VEC_LANE_SEQ_MASK_EN
    logic [LANES-1:0]    in_mask;
`endif
    logic [15:0]         alu_a, alu_b, alu_c;
    logic [2:0]          alu_opcode;
    logic                alu_flag_scalar;
    logic [31:0]         alu_instance;
    logic [15:0]         alu_result;
    logic [3:0]          alu_flags;
    logic                out_valid;
    logic                out_ready;
    logic [16*LANES-1:0] out_vec;
    logic [4*LANES-1:0]  out_lane_flags;
    logic [3:0]          out_flags;
    logic                out_err;

    always #5 clk = ~clk;

    vec_lane_sequencer #(.LANES(LANES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_scalar(in_scalar), .in_scalar_val(in_scalar_val),
        .in_vec_a(in_vec_a), .in_vec_b(in_vec_b), .in_vec_c(in_vec_c),
`ifdef VEC_LANE_SEQ_MASK_EN
        .in_mask(in_mask),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_opcode(alu_opcode), .alu_flag_scalar(alu_flag_scalar),
        .alu_instance(alu_instance),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_lane_flags(out_lane_flags),
        .out_flags(out_flags), .out_err(out_err)
    );

    // Behavioural lane ALU: returns {result, V, N, Z, C}.
    function automatic logic [19:0] alu_model(input logic [2:0] op,
                                              input logic [15:0] a, b, c);
        logic [16:0]        s;
        logic [15:0]        r;
        logic               v, cy;
        logic signed [31:0] p;
        r  = 16'h0;
        v  = 1'b0;
        cy = 1'b0;
        s  = 17'h0;
        p  = 32'sh0;
        case (op)
            3'b010: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[15:0];
                cy = s[16];
                v  = (a[15] == b[15]) && (r[15] != a[15]);
            end
            3'b001: begin
                r  = a - b;
                cy = (a < b);
                v  = (a[15] != b[15]) && (r[15] != a[15]);
            end
            3'b000: begin
                p = $signed(a) * $signed(b);
                r = p[23:8];
                v = !((p[31:23] == 9'h000) || (p[31:23] == 9'h1FF));
            end
            3'b111: r = c;
            default: r = 16'h0;
        endcase
        return {r, v, r[15], (r == 16'h0), cy};
    endfunction

    always_comb begin
        {alu_result, alu_flags} = alu_model(alu_opcode, alu_a, alu_b, alu_c);
    end

    function automatic logic [63:0] v4(input logic [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [15:0] f4(input logic [3:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    typedef struct {
        logic [63:0] vec;
        logic [15:0] lf;
        logic [3:0]  fl;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] tr_inst [16];
    logic [15:0] tr_a    [16];
    logic [15:0] tr_b    [16];
    int          tr_n;

    // Operand sets shared by several scenarios.
    logic [63:0] A1, B1, C1, A3, B3;
    initial begin
        A1 = v4(16'h0280, 16'h01c0, 16'hfc80, 16'h7f00);
        B1 = v4(16'h0280, 16'h00e0, 16'h0500, 16'h0200);
        C1 = v4(16'h1111, 16'h2222, 16'h3333, 16'habcd);
        A3 = v4(16'h0F00, 16'h0180, 16'h00C0, 16'hFF40);
        B3 = v4(16'h0800, 16'h01C0, 16'hFFA0, 16'h0040);
    end

    // Offer one operation and return just after the accepting edge, then
    // scramble the inputs so any late sampling by the DUT shows up.
    task automatic send(input logic [2:0] op, input logic sc, input logic [15:0] sv,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_opcode     = op;
        in_scalar     = sc;
        in_scalar_val = sv;
        in_vec_a      = a;
        in_vec_b      = b;
        in_vec_c      = c;
        in_valid      = 1'b1;
        @(posedge clk); #1;
        in_valid      = 1'b0;
        in_opcode     = 3'b001;
        in_scalar     = ~sc;
        in_scalar_val = 16'h7777;
        in_vec_a      = {$urandom(), $urandom()};
        in_vec_b      = {$urandom(), $urandom()};
        in_vec_c      = {$urandom(), $urandom()};
    endtask

    // Count edges (accepting edge = 1) until out_valid, tracing ALU drive.
    task automatic wait_valid(output int edges);
        edges = 1;
        tr_n  = 0;
        while (!out_valid && edges < 40) begin
            if (tr_n < 16) begin
                tr_inst[tr_n] = alu_instance;
                tr_a[tr_n]    = alu_a;
                tr_b[tr_n]    = alu_b;
                tr_n++;
            end
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        n_cmp++;
        if (out_vec !== 64'h0 || out_lane_flags !== 16'h0 || out_flags !== 4'h0 || out_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out: vec=%h lf=%h fl=%b err=%b required all 0",
                     out_vec, out_lane_flags, out_flags, out_err);
        end
        n_cmp++;
        if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_c !== 16'h0 || alu_instance !== 32'h0 ||
            alu_opcode !== 3'b0 || alu_flag_scalar !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_alu: a=%h b=%h c=%h inst=%0d op=%b required 0",
                     alu_a, alu_b, alu_c, alu_instance, alu_opcode);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        exp_t e;
        int   edges;
        sb.push_back('{vec: v4(16'h0500, 16'h02a0, 16'h0180, 16'h8100),
                       lf:  f4(4'b0000, 4'b0000, 4'b0001, 4'b1100),
                       fl:  4'b1101, err: 1'b0});
        send(3'b010, 1'b0, 16'h0, A1, B1, C1);
        wait_valid(edges);
        n_cmp++;
        if (edges !== 5) begin
            n_bad++;
            $display("FAIL add_latency: edges=%0d required 5", edges);
        end
        e = sb.pop_front();
        n_cmp++;
        if (out_vec !== e.vec || out_lane_flags !== e.lf) begin
            n_bad++;
            $display("FAIL add_data: vec=%h lf=%h required %h %h", out_vec, out_lane_flags, e.vec, e.lf);
        end
        n_cmp++;
        if (out_flags !== e.fl || out_err !== e.err) begin
            n_bad++;
            $display("FAIL add_flags: fl=%b err=%b required %b %b", out_flags, out_err, e.fl, e.err);
        end
        for (int k = 0; k < LANES; k++) begin
            n_cmp++;
            if (tr_inst[k] !== 32'(k) || tr_a[k] !== A1[16*k +: 16] || tr_b[k] !== B1[16*k +: 16]) begin
                n_bad++;
                $display("FAIL add_drive%0d: inst=%0d a=%h b=%h required %0d %h %h",
                         k, tr_inst[k], tr_a[k], tr_b[k], k, A1[16*k +: 16], B1[16*k +: 16]);
            end
        end
        handoff();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL add_handoff: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_scalar_mul();
        exp_t e;
        int   edges;
        sb.push_back('{vec: v4(16'hFE80, 16'h0100, 16'h0200, 16'h0000),
                       lf:  f4(4'b0100, 4'b0000, 4'b0000, 4'b0010),
                       fl:  4'b0100, err: 1'b0});
        send(3'b000, 1'b1, 16'h0080, v4(16'hFD00, 16'h0200, 16'h0400, 16'h0000), B1, C1);
        wait_valid(edges);
        n_cmp++;
        if (edges !== 5 || tr_n !== 4) begin
            n_bad++;
            $display("FAIL mul_latency: edges=%0d run_cycles=%0d required 5/4", edges, tr_n);
        end
        for (int k = 0; k < LANES; k++) begin
            n_cmp++;
            if (tr_inst[k] !== 32'(k) || tr_b[k] !== 16'h0080) begin
                n_bad++;
                $display("FAIL mul_scalar%0d: inst=%0d b=%h required %0d 0080", k, tr_inst[k], tr_b[k], k);
            end
        end
        e = sb.pop_front();
        n_cmp++;
        if (out_vec !== e.vec || out_lane_flags !== e.lf || out_flags !== e.fl) begin
            n_bad++;
            $display("FAIL mul_data: vec=%h lf=%h fl=%b required %h %h %b",
                     out_vec, out_lane_flags, out_flags, e.vec, e.lf, e.fl);
        end
        n_cmp++;
        if (alu_flag_scalar !== 1'b1 || alu_opcode !== 3'b000) begin
            n_bad++;
            $display("FAIL mul_frozen: scalar=%b op=%b required 1 000", alu_flag_scalar, alu_opcode);
        end
        handoff();
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   edges;
        sb.push_back('{vec: v4(16'h0700, 16'hFFC0, 16'h0120, 16'hFF00),
                       lf:  f4(4'b0000, 4'b0101, 4'b0001, 4'b0100),
                       fl:  4'b0101, err: 1'b0});
        send(3'b001, 1'b0, 16'h0, A3, B3, C1);
        wait_valid(edges);
        e = sb.pop_front();
        n_cmp++;
        if (out_vec !== e.vec || out_flags !== e.fl || out_lane_flags !== e.lf) begin
            n_bad++;
            $display("FAIL sub_data: vec=%h fl=%b lf=%h required %h %b %h",
                     out_vec, out_flags, out_lane_flags, e.vec, e.fl, e.lf);
        end
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_vec !== e.vec ||
                out_lane_flags !== e.lf || out_flags !== e.fl || out_err !== 1'b0) begin
                n_bad++;
                $display("FAIL sub_stall%0d: valid=%b in_ready=%b vec=%h fl=%b required 1 0 %h %b",
                         k, out_valid, in_ready, out_vec, out_flags, e.vec, e.fl);
            end
        end
        in_valid = 1'b0;
        handoff();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL sub_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_set_illegal();
        exp_t        e;
        int          edges;
        logic [63:0] cs;
        cs = v4(16'hFF00, 16'h0000, 16'h1234, 16'h0100);
        sb.push_back('{vec: cs, lf: f4(4'b0100, 4'b0010, 4'b0000, 4'b0000),
                       fl: 4'b0100, err: 1'b0});
        send(3'b111, 1'b0, 16'h0, A3, B3, cs);
        wait_valid(edges);
        e = sb.pop_front();
        n_cmp++;
        if (edges !== 5 || out_vec !== e.vec || out_lane_flags !== e.lf || out_flags !== e.fl) begin
            n_bad++;
            $display("FAIL set_data: edges=%0d vec=%h lf=%h fl=%b required 5 %h %h %b",
                     edges, out_vec, out_lane_flags, out_flags, e.vec, e.lf, e.fl);
        end
        handoff();
        sb.push_back('{vec: 64'h0, lf: 16'h0, fl: 4'b0000, err: 1'b1});
        send(3'b011, 1'b0, 16'h0, A1, B1, C1);
        wait_valid(edges);
        n_cmp++;
        if (edges !== 1) begin
            n_bad++;
            $display("FAIL illegal_latency: edges=%0d required 1", edges);
        end
        e = sb.pop_front();
        n_cmp++;
        if (out_err !== e.err || out_vec !== e.vec || out_lane_flags !== e.lf || out_flags !== e.fl) begin
            n_bad++;
            $display("FAIL illegal_out: err=%b vec=%h lf=%h fl=%b required 1 0 0 0",
                     out_err, out_vec, out_lane_flags, out_flags);
        end
        handoff();
        n_cmp++;
        if (out_err !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_clear: err=%b valid=%b required 0/0", out_err, out_valid);
        end
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        int   edges;
        send(3'b010, 1'b0, 16'h0, A3, B3, C1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (alu_instance !== 32'd2) begin
            n_bad++;
            $display("FAIL midrun_lane: inst=%0d required 2", alu_instance);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_vec !== 64'h0 ||
            out_lane_flags !== 16'h0 || out_flags !== 4'h0 || out_err !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_async: in_ready=%b valid=%b vec=%h lf=%h required 1 0 0 0",
                     in_ready, out_valid, out_vec, out_lane_flags);
        end
        n_cmp++;
        if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_instance !== 32'h0) begin
            n_bad++;
            $display("FAIL midrun_alu: a=%h b=%h inst=%0d required 0", alu_a, alu_b, alu_instance);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_emit: out_valid=%b required 0", out_valid);
        end
        sb.push_back('{vec: v4(16'h0500, 16'h02a0, 16'h0180, 16'h8100),
                       lf:  f4(4'b0000, 4'b0000, 4'b0001, 4'b1100),
                       fl:  4'b1101, err: 1'b0});
        send(3'b010, 1'b0, 16'h0, A1, B1, C1);
        wait_valid(edges);
        e = sb.pop_front();
        n_cmp++;
        if (edges !== 5 || out_vec !== e.vec || out_lane_flags !== e.lf || out_flags !== e.fl) begin
            n_bad++;
            $display("FAIL midrun_next: edges=%0d vec=%h lf=%h fl=%b required 5 %h %h %b",
                     edges, out_vec, out_lane_flags, out_flags, e.vec, e.lf, e.fl);
        end
        handoff();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   edges;
        sb.push_back('{vec: v4(16'h0500, 16'h02a0, 16'h0180, 16'h8100),
                       lf:  f4(4'b0000, 4'b0000, 4'b0001, 4'b1100),
                       fl:  4'b1101, err: 1'b0});
        send(3'b010, 1'b0, 16'h0, A1, B1, C1);
        wait_valid(edges);
        e = sb.pop_front();
        n_cmp++;
        if (out_vec !== e.vec || out_flags !== e.fl) begin
            n_bad++;
            $display("FAIL b2b_first: vec=%h fl=%b required %h %b", out_vec, out_flags, e.vec, e.fl);
        end
        sb.push_back('{vec: v4(16'h0700, 16'hFFC0, 16'h0120, 16'hFF00),
                       lf:  f4(4'b0000, 4'b0101, 4'b0001, 4'b0100),
                       fl:  4'b0101, err: 1'b0});
        in_opcode = 3'b001;
        in_scalar = 1'b0;
        in_vec_a  = A3;
        in_vec_b  = B3;
        in_vec_c  = C1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_no_overlap: in_ready=%b valid=%b required 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec_a = 64'h0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_accept: in_ready=%b required 0", in_ready);
        end
        wait_valid(edges);
        e = sb.pop_front();
        n_cmp++;
        if (edges !== 5 || out_vec !== e.vec || out_lane_flags !== e.lf || out_flags !== e.fl) begin
            n_bad++;
            $display("FAIL b2b_second: edges=%0d vec=%h lf=%h fl=%b required 5 %h %h %b",
                     edges, out_vec, out_lane_flags, out_flags, e.vec, e.lf, e.fl);
        end
        handoff();
    endtask

`ifdef VEC_LANE_SEQ_MASK_EN
    task automatic test_mask();
        exp_t e;
        int   edges;
        in_mask = 4'b0111;
        sb.push_back('{vec: v4(16'h0500, 16'h02a0, 16'h0180, 16'habcd),
                       lf:  f4(4'b0000, 4'b0000, 4'b0001, 4'b0000),
                       fl:  4'b0001, err: 1'b0});
        send(3'b010, 1'b0, 16'h0, A1, B1, C1);
        in_mask = 4'b1111;
        wait_valid(edges);
        e = sb.pop_front();
        n_cmp++;
        if (edges !== 5 || out_vec !== e.vec || out_lane_flags !== e.lf || out_flags !== e.fl) begin
            n_bad++;
            $display("FAIL mask_partial: edges=%0d vec=%h lf=%h fl=%b required 5 %h %h %b",
                     edges, out_vec, out_lane_flags, out_flags, e.vec, e.lf, e.fl);
        end
        handoff();
        in_mask = 4'b0000;
        sb.push_back('{vec: C1, lf: 16'h0, fl: 4'b0010, err: 1'b0});
        send(3'b010, 1'b0, 16'h0, A1, B1, C1);
        in_mask = 4'b1111;
        wait_valid(edges);
        e = sb.pop_front();
        n_cmp++;
        if (edges !== 5 || out_vec !== e.vec || out_lane_flags !== e.lf || out_flags !== e.fl) begin
            n_bad++;
            $display("FAIL mask_all: edges=%0d vec=%h lf=%h fl=%b required 5 %h %h %b",
                     edges, out_vec, out_lane_flags, out_flags, e.vec, e.lf, e.fl);
        end
        handoff();
    endtask
`endif

    initial begin
        rst           = 1'b0;
        in_valid      = 1'b0;
        in_opcode     = 3'b000;
        in_scalar     = 1'b0;
        in_scalar_val = 16'h0;
        in_vec_a      = 64'h0;
        in_vec_b      = 64'h0;
        in_vec_c      = 64'h0;
        out_ready     = 1'b0;
`ifdef VEC_LANE_SEQ_MASK_EN
        in_mask       = 4'b1111;
`endif
        test_reset();
        test_add();
        test_scalar_mul();
        test_backpressure();
        test_set_illegal();
        test_reset_midrun();
        test_back_to_back();
`ifdef VEC_LANE_SEQ_MASK_EN
        test_mask();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vec_lane_sequencer.md
Name: vec_lane_sequencer

Overview:
Multi-cycle vector execute controller that time-multiplexes one combinational Q7.8 lane ALU (ALU_vec_aux) across a vector of LANES 16-bit elements.
- Upstream: accepts a vector operation from decode over a valid/ready handshake.
- Lane ALU: drives the ALU's data_a/data_b/data_c/opcode/flag_scalar/instance_num one lane per cycle, and captures result/flags in the same cycle.
- Downstream: presents the assembled result vector, per-lane flags and aggregated flags to writeback over a valid/ready handshake.

Parameters:
LANES, 4, number of 16-bit elements per vector (2..16)
IDX_W, $clog2(LANES), lane index width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  operation offered
in_ready  out  1  sequencer can accept (high only in IDLE)
in_opcode  in  3  000 mul, 001 sub, 010 add, 111 set; others illegal
in_scalar  in  1  1: operand B of every lane is in_scalar_val
in_scalar_val  in  16  scalar Q7.8 operand
in_vec_a  in  16*LANES  lane i at [16i+15:16i]
in_vec_b  in  16*LANES  same packing
in_vec_c  in  16*LANES  same packing (set-source)
alu_a, alu_b, alu_c  out  16  lane operands to ALU
alu_opcode  out  3  latched opcode
alu_flag_scalar  out  1  latched scalar flag
alu_instance  out  32  current lane index, zero-extended
alu_result  in  16  ALU result, same cycle
alu_flags  in  4  ALU flags {V,N,Z,C}, same cycle
out_valid  out  1  result available
out_ready  in  1  writeback accepts
out_vec  out  16*LANES  result vector
out_lane_flags  out  4*LANES  lane i flags at [4i+3:4i]
out_flags  out  4  aggregated {V,N,Z,C}
out_err  out  1  illegal opcode

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, idx=0.
  - All latched operands, out_vec, out_lane_flags, out_flags, out_err and alu_* outputs = 0.
  - in_ready=1, out_valid=0.
  - Reset mid-RUN or mid-DONE abandons the operation; nothing is emitted.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch all in_* fields, clear out_lane_flags and out_vec, idx=0.
  - Legal opcode: go to RUN. Illegal opcode: out_err=1, out_vec=0, out_flags=0, go directly to DONE.
- RUN, per cycle:
  - alu_a = a[idx]; alu_b = scalar ? scalar_val : b[idx]; alu_c = c[idx]; alu_instance = idx.
  - At the edge, res[idx] <= alu_result and lflags[idx] <= alu_flags.
  - If idx==LANES-1: go to DONE. Otherwise idx <= idx+1.
  - in_ready=0.
- Operand drive: alu_* outputs are combinational from latched state and idx. In non-RUN states they hold lane 0 operands.
- Aggregation on entry to DONE, computed over all lanes:
  - V = OR of lane V.
  - N = OR of lane N.
  - Z = AND of lane Z.
  - C = OR of lane C.
- DONE:
  - out_valid=1. out_vec, out_lane_flags, out_flags and out_err stay stable until out_ready.
  - On out_valid&&out_ready: go to IDLE, clear out_err. out_valid drops the next cycle.
  - No new input is accepted in the same cycle as output handoff.
- Latency:
  - Legal op: out_valid rises LANES+1 rising edges after the accepting edge.
  - Illegal op: out_valid rises 1 edge after the accepting edge.
- Throughput: one op per LANES+2 cycles minimum.
- Opcode and scalar settings are frozen for the whole operation; in_* changes during RUN are ignored.

Optional Feature:
VEC_LANE_SEQ_MASK_EN
- With the macro: adds input in_mask [LANES-1:0], latched at accept.
  - Lanes with mask=0 still consume their RUN cycle, so latency is unchanged.
  - Masked lanes: res[i] = c[i] pass-through, lflags[i] = 0000.
  - Masked lanes are excluded from aggregation: they count as Z=1 for the AND and 0 for the ORs.
  - All lanes masked: out_flags = 0010.
- Without the macro: port absent; all lanes active.

Test Plan:
1. Add, LANES=4.
   - Stimulus: a={0280,01c0,fc80,7f00}, b={0280,00e0,0500,0200}, opcode 010.
   - Required: out_vec={0500,02a0,0180,8100}; lane flags {0000,0000,0001,1100}; out_flags=1101; out_valid exactly 5 edges after accept.
2. Scalar mul.
   - Stimulus: a={FD00,0200,0400,0000}, scalar=1, scalar_val=0080, opcode 000.
   - Required: out_vec={FE80,0100,0200,0000}; alu_b=0080 on every RUN cycle; alu_instance steps 0,1,2,3.
3. Sub plus backpressure.
   - Stimulus: a={0F00,0180,00C0,FF40}, b={0800,01C0,FFA0,0040}, opcode 001; hold out_ready=0 for 10 cycles.
   - Required: out_vec={0700,FFC0,0120,FF00}; out_flags=0101; out_valid and data stable throughout; in_ready=0 until the cycle after handoff.
4. Set and illegal opcode.
   - Opcode 111 with c={FF00,0000,1234,0100}: out_vec equals c.
   - Then opcode 011: out_err=1, out_vec=0, out_valid one edge after accept, err cleared after handoff.
5. Reset mid-RUN.
   - Stimulus: assert rst low asynchronously during lane 2.
   - Required: immediately in_ready=1, out_valid=0, outputs 0. The next accepted add op completes correctly.
6. With VEC_LANE_SEQ_MASK_EN.
   - Stimulus: test 1 with mask=0111.
   - Required: lane 3 = c[3], lane flags 0000; out_flags=0001.
